vga_timing_decoder: RTL
=======================

Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the 800x525 VGA pixel address generator.
- Watches an incoming active-low hsync_n/vsync_n pair and recovers the pixel column/row the transmitter is on.
- Locks to the stream and flags timing violations.
- Used as a monitor/checker on the VGA output path, and as the coordinate source for downstream capture logic.

Parameters:
- H_TOTAL, 800, pixels per line (col wraps 799 -> 0)
- V_TOTAL, 525, lines per frame (row wraps 524 -> 0)
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- H_SYNC_START, 656, column at which hsync_n falls
- H_SYNC_W, 96, hsync_n low width in pixels
- V_SYNC_START, 490, row at which vsync_n falls (at col 0)
- V_SYNC_W, 2, vsync_n low width in lines

Ports:
- clk  in  1  pixel clock, same clock as the transmitter
- rst_n  in  1  synchronous active-low reset
- hsync_n  in  1  horizontal sync, active low
- vsync_n  in  1  vertical sync, active low
- col  out  16  recovered column of the sampled pixel
- row  out  16  recovered row of the sampled pixel
- pix_valid  out  1  locked & col<H_ACTIVE & row<V_ACTIVE
- locked  out  1  decoder is in LOCKED state
- frame_start  out  1  one-cycle pulse when locked and (col,row)=(0,0)
- sync_err  out  1  one-cycle pulse on any detected timing violation while locked
- err_count  out  8  saturating count of sync_err pulses; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge), effective the next cycle:
  - State goes to SEARCH.
  - col, row, pix_valid, locked, frame_start, sync_err and err_count all go to 0.
  - The input sample registers go to 1 (idle).
  - Reset mid-frame discards lock immediately.
- Inputs are registered once. Edges are detected on the registered sample against its previous value.
- Latency: the outputs in cycle t+1 describe the pixel whose syncs were presented in cycle t.
- Counters: col increments every cycle and wraps H_TOTAL-1 -> 0. row increments when col wraps and wraps V_TOTAL-1 -> 0.
  - Both are 16-bit unsigned.
  - Counters free-run in every state, except where a load below applies.
- FSM states: SEARCH, H_LOCK, LOCKED.
  - SEARCH:
    - On an hsync_n falling edge, load col=H_SYNC_START and go to H_LOCK.
    - row holds 0.
  - H_LOCK:
    - Tracks columns. Each hsync fall must occur when the next col would be H_SYNC_START; on a miss, reload col and stay in H_LOCK.
    - On a vsync_n falling edge, load row=V_SYNC_START and col=0. Go to LOCKED only if that edge coincides with the col wrap; otherwise stay in H_LOCK.
  - LOCKED: counters free-run. Each pixel is checked against the expected sync levels:
    - hsync_n low iff H_SYNC_START <= col < H_SYNC_START+H_SYNC_W.
    - vsync_n low iff V_SYNC_START <= row < V_SYNC_START+V_SYNC_W. vsync_n changes only at col 0.
    - Any mismatch pulses sync_err, increments err_count (saturates at 255, no wrap) and returns to SEARCH.
    - On that same cycle locked drops, and col/row reload per SEARCH rules; a coincident hsync fall is honoured, moving the FSM to H_LOCK.
- Simultaneous hsync and vsync falling edges are legal only if col == H_SYNC_START == 0; with default parameters this is an error in LOCKED.
- pix_valid, frame_start and locked are 0 outside LOCKED.
- A frame_start pulse requires a full wrap from row 524 to row 0. No frame_start is emitted on the cycle lock is first acquired.

Test Plan:
- Reset then 3 clean frames from the pixel address generator:
  - locked=1 from the first vsync fall (row 490, col 0) onward.
  - Outputs match the generator's Hpix/Vpix delayed by 1 cycle on every cycle.
  - frame_start pulses exactly 2 times; err_count=0.
- Locked stream:
  - pix_valid=1 for exactly 640x480=307200 cycles per frame.
  - pix_valid=0 at col 640 and at row 480.
- Single hsync glitch (one cycle low at col 100, row 10):
  - sync_err pulses once; locked=0; err_count=1.
  - Relock at the next vsync fall, then no further errors.
- Hsync width 95 instead of 96:
  - sync_err at col 751; state goes to SEARCH.
  - Relock within 1 frame.
- 300 injected errors: err_count saturates at 255.
- rst_n low for 1 cycle at row 200, col 300 while locked:
  - All outputs 0 the next cycle.
  - Relock at the next vsync fall (row 490, col 0), with col/row matching the generator thereafter.

Source files
------------

// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - recovers VGA pixel column/row from hsync_n/vsync_n and checks sync timing
module vga_timing_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_W     = 96,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_W     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [15:0] col,
  output logic [15:0] row,
  output logic        pix_valid,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG  = 16'(H_SYNC_START);
  localparam logic [15:0] HS_END  = 16'(H_SYNC_START + H_SYNC_W);
  localparam logic [15:0] VS_BEG  = 16'(V_SYNC_START);
  localparam logic [15:0] VS_END  = 16'(V_SYNC_START + V_SYNC_W);
  localparam logic        HS_AT_0 = (H_SYNC_START == 0);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    H_LOCK = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  // sample registers hold the sync levels of the previously presented pixel
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        pix_valid_q, pix_valid_d;
  logic        locked_q, locked_d;
  logic        frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        h_fall, v_fall;
  logic        col_wrap;
  logic [15:0] col_inc, row_inc;
  logic        exp_h_low, exp_v_low;
  logic        mismatch;

  assign h_fall = hs_q & ~hsync_n;
  assign v_fall = vs_q & ~vsync_n;

  // free-running counter step and the sync levels expected at the stepped position
  always_comb begin
    col_wrap  = (col_q == H_LAST);
    col_inc   = col_wrap ? 16'd0 : col_q + 16'd1;
    row_inc   = row_q;
    if (col_wrap) begin
      row_inc = (row_q == V_LAST) ? 16'd0 : row_q + 16'd1;
    end
    exp_h_low = (col_inc >= HS_BEG) && (col_inc < HS_END);
    exp_v_low = (row_inc >= VS_BEG) && (row_inc < VS_END);
    // a pin equal to its "expected low" flag is at the wrong level
    mismatch  = (hsync_n == exp_h_low) || (vsync_n == exp_v_low) ||
                (h_fall && v_fall && !(HS_AT_0 && col_inc == HS_BEG));
  end

  // next-state, counter loads and output flags
  always_comb begin
    state_d     = state_q;
    hs_d        = hsync_n;
    vs_d        = vsync_n;
    col_d       = col_inc;
    row_d       = row_inc;
    sync_err_d  = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      SEARCH: begin
        row_d = 16'd0;
        if (h_fall) begin
          col_d   = HS_BEG;
          state_d = H_LOCK;
        end
      end
      H_LOCK: begin
        if (v_fall) begin
          col_d = 16'd0;
          row_d = VS_BEG;
          if (col_wrap) begin
            state_d = LOCKED;
          end
        end else if (h_fall && col_inc != HS_BEG) begin
          col_d = HS_BEG;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          sync_err_d = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          // drop to SEARCH, but a fall on this very pixel already starts H_LOCK
          row_d = 16'd0;
          if (h_fall) begin
            col_d   = HS_BEG;
            state_d = H_LOCK;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
    locked_d      = (state_d == LOCKED);
    pix_valid_d   = locked_d && (col_d < H_ACT) && (row_d < V_ACT);
    frame_start_d = locked_d && (state_q == LOCKED) && (col_d == 16'd0) && (row_d == 16'd0);
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      col_q         <= 16'd0;
      row_q         <= 16'd0;
      pix_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_valid_q   <= pix_valid_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign col         = col_q;
  assign row         = row_q;
  assign pix_valid   = pix_valid_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;

endmodule
